// File: rtl/primera_prueba_nco_gen_pkg.sv
// Shared NCO definitions: default widths, quadrant type and the quarter-wave
// table formula used to build the sine ROM at elaboration time.
package nco_pkg;

    localparam int PHASE_W = 32;
    localparam int OUT_W   = 14;
    localparam int LUT_W   = 10;

    // Top two bits of the looked-up phase select the quarter of the sine cycle.
    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quadrant_t;

    // Q[k] = round(A * sin(2*pi*(k+0.5)/N)), A = 2^(out_w-1)-1, N = 2^lut_w.
    // The half-sample offset makes the four quadrants exact mirrors of each
    // other and keeps every sample away from zero. Values are always positive,
    // so adding 0.5 before truncation rounds to nearest.
    function automatic int sine_q(input int k,
                                  input int lut_w = LUT_W,
                                  input int out_w = OUT_W);
        real amp;
        real ph;
        amp = real'((1 << (out_w - 1)) - 1);
        ph  = 2.0 * 3.14159265358979323846 * (real'(k) + 0.5) / real'(1 << lut_w);
        return $rtoi(amp * $sin(ph) + 0.5);
    endfunction

endpackage

// File: rtl/primera_prueba_nco_gen_sine_rom.sv
// Quarter-wave sine magnitude table with a registered read port. Contents are
// generated from nco_pkg::sine_q, so the table follows the width parameters.
module nco_sine_rom #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] o_data
);
    import nco_pkg::*;

    logic [DATA_W-1:0] w_table [2**ADDR_W];
    logic [DATA_W-1:0] r_data;

    // One constant entry per address; the full cycle has 4 * 2^ADDR_W points.
    generate
        for (genvar gi = 0; gi < 2**ADDR_W; gi++) begin : g_table
            assign w_table[gi] = DATA_W'(sine_q(gi, ADDR_W + 2, DATA_W + 1));
        end
    endgenerate

    // Registered read, frozen while the pipeline is disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
        end else if (i_en) begin
            r_data <= w_table[i_addr];
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/primera_prueba_nco_gen.sv
// Numerically controlled oscillator: phase accumulator, quadrant fold into a
// quarter-wave ROM and a 3-stage pipeline producing a signed sine stream.
module primera_prueba_nco_gen #(
    parameter int PHASE_W = nco_pkg::PHASE_W,
    parameter int OUT_W   = nco_pkg::OUT_W,
    parameter int LUT_W   = nco_pkg::LUT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clken,
    input  logic [PHASE_W-1:0]       phi_inc_i,
    output logic signed [OUT_W-1:0]  fsin_o,
    output logic                     out_valid
);
    import nco_pkg::*;

    localparam int ADDR_W = LUT_W - 2;

    logic [PHASE_W-1:0]      r_acc;
    logic [LUT_W-1:0]        w_p;
    quadrant_t               w_quad;
    logic [ADDR_W-1:0]       w_a;
    logic [ADDR_W-1:0]       w_k;
    logic                    w_neg;
    logic [ADDR_W-1:0]       r_addr;
    logic                    r_sign1;
    logic                    r_sign2;
    logic [OUT_W-2:0]        w_rom_data;
    logic signed [OUT_W-1:0] w_mag;
    logic signed [OUT_W-1:0] r_fsin;
    logic [2:0]              r_valid;

    // Phase accumulator; wraps naturally and is never cleared by an increment change.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
        end else if (clken) begin
            r_acc <= r_acc + phi_inc_i;
        end
    end

    // Fold: quadrants 1 and 3 run the table backwards, quadrants 2 and 3 are negative.
    assign w_p    = r_acc[PHASE_W-1 -: LUT_W];
    assign w_quad = quadrant_t'(w_p[LUT_W-1 -: 2]);
    assign w_a    = w_p[ADDR_W-1:0];
    assign w_k    = (w_quad == QUAD_1 || w_quad == QUAD_3) ? ~w_a : w_a;
    assign w_neg  = (w_quad == QUAD_2 || w_quad == QUAD_3);

    // Stage 1: register the folded table address and the sign.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr  <= '0;
            r_sign1 <= 1'b0;
        end else if (clken) begin
            r_addr  <= w_k;
            r_sign1 <= w_neg;
        end
    end

    // Stage 2: ROM data register lives in the table; the sign follows it here.
    nco_sine_rom #(
        .ADDR_W (ADDR_W),
        .DATA_W (OUT_W - 1)
    ) u_rom (
        .clk    (clk),
        .reset  (reset),
        .i_en   (clken),
        .i_addr (r_addr),
        .o_data (w_rom_data)
    );

    // Delay the sign to line up with the ROM output.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sign2 <= 1'b0;
        end else if (clken) begin
            r_sign2 <= r_sign1;
        end
    end

    // Magnitude never exceeds 2^(OUT_W-1)-1, so negation cannot overflow.
    assign w_mag = signed'({1'b0, w_rom_data});

    // Stage 3: apply the sign into the output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsin <= '0;
        end else if (clken) begin
            r_fsin <= r_sign2 ? -w_mag : w_mag;
        end
    end

    // Valid pipe fills with ones, one stage per enabled edge, and stays full.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else if (clken) begin
            r_valid <= {r_valid[1:0], 1'b1};
        end
    end

    assign fsin_o    = r_fsin;
    assign out_valid = r_valid[2];

endmodule

// File: tb/tb_primera_prueba_nco_gen.sv
// Scoreboard bench for the NCO: the driver queues hand-computed samples for
// each scenario, the monitor pops one on every enabled edge with out_valid.
module tb_primera_prueba_nco_gen;

    logic               clk = 1'b0;
    logic               reset;
    logic               clken;
    logic [31:0]        phi_inc_i;
    logic signed [13:0] fsin_o;
    logic               out_valid;

    typedef struct {
        logic signed [13:0] val;
        bit                 full;   // 0: compare sign bit only
        string              name;
        int                 idx;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    primera_prueba_nco_gen dut (
        .clk       (clk),
        .reset     (reset),
        .clken     (clken),
        .phi_inc_i (phi_inc_i),
        .fsin_o    (fsin_o),
        .out_valid (out_valid)
    );

    always #4 clk = ~clk;

    function automatic void push(input int v, input bit full, input string nm, input int idx);
        exp_t e;
        e.val  = 14'(v);
        e.full = full;
        e.name = nm;
        e.idx  = idx;
        sb_q.push_back(e);
    endfunction

    // Quadrant-boundary sequence for a quarter-cycle increment.
    task automatic push_quarter(input string nm, input int count);
        int pat[4];
        pat = '{25, 8191, -25, -8191};
        for (int n = 0; n < count; n++) push(pat[n % 4], 1'b1, nm, n);
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_cycle(input logic en, input string nm);
        reset = 1'b1;
        clken = en;
        step(1);
        reset = 1'b0;
        check({nm, "_fsin"}, fsin_o, 0);
        check({nm, "_valid"}, out_valid, 0);
    endtask

    task automatic startup_check(input string nm);
        clken = 1'b1;
        step(1);
        check({nm, "_valid_e1"}, out_valid, 0);
        step(1);
        check({nm, "_valid_e2"}, out_valid, 0);
    endtask

    // Monitor: one sample per enabled, non-reset edge once out_valid is high.
    initial begin
        bit   en_s;
        bit   rst_s;
        bit   ok;
        exp_t e;
        forever begin
            @(posedge clk);
            en_s  = clken;
            rst_s = reset;
            #1;
            if (en_s && !rst_s && out_valid) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_sample: got %0d, expected no sample", fsin_o);
                end else begin
                    e  = sb_q.pop_front();
                    ok = e.full ? (fsin_o == e.val) : (fsin_o[13] == e.val[13]);
                    if (!ok) begin
                        n_err++;
                        if (e.full)
                            $display("FAIL %s[%0d]: got %0d, expected %0d", e.name, e.idx, fsin_o, e.val);
                        else
                            $display("FAIL %s[%0d] sign: got %0b, expected %0b", e.name, e.idx, fsin_o[13], e.val[13]);
                    end
                end
            end
        end
    end

    // Driver.
    initial begin
        int m;
        int pat[4];
        pat       = '{25, 8191, -25, -8191};
        reset     = 1'b1;
        clken     = 1'b0;
        phi_inc_i = '0;
        step(2);
        reset = 1'b0;
        check("reset_fsin", fsin_o, 0);
        check("reset_valid", out_valid, 0);

        // Quarter-cycle increment: 10 edges give samples 0..7.
        phi_inc_i = 32'h4000_0000;
        push_quarter("inc_quarter", 8);
        startup_check("inc_quarter");
        step(8);
        $display("scenario inc_quarter done, pending=%0d", sb_q.size());

        // Zero increment: phase stays 0, output stays at Q[0].
        reset_cycle(1'b1, "rst_a");
        phi_inc_i = 32'h0;
        for (int n = 0; n < 6; n++) push(25, 1'b1, "inc_zero", n);
        startup_check("inc_zero");
        step(6);
        check("inc_zero_valid_hold", out_valid, 1);
        $display("scenario inc_zero done, pending=%0d", sb_q.size());

        // 256-sample period: quadrant points exact, sign by half-cycle.
        reset_cycle(1'b1, "rst_b");
        phi_inc_i = 32'h0100_0000;
        for (int n = 0; n < 260; n++) begin
            m = n % 256;
            if (m % 64 == 0) push(pat[m / 64], 1'b1, "inc_256", n);
            else             push((m >= 128) ? -1 : 1, 1'b0, "inc_256", n);
        end
        clken = 1'b1;
        step(262);
        $display("scenario inc_256 done, pending=%0d", sb_q.size());

        // clken pause: output holds, then resumes without skip or repeat.
        reset_cycle(1'b1, "rst_c");
        phi_inc_i = 32'h4000_0000;
        push_quarter("pause_pre", 4);
        clken = 1'b1;
        step(6);
        clken = 1'b0;
        for (int n = 0; n < 5; n++) begin
            step(1);
            check("pause_fsin_hold", fsin_o, -8191);
            check("pause_valid_hold", out_valid, 1);
        end
        for (int n = 4; n < 10; n++) push(pat[n % 4], 1'b1, "pause_post", n);
        clken = 1'b1;
        step(6);
        $display("scenario clken_pause done, pending=%0d", sb_q.size());

        // Reset while disabled, then restart identical to the first run.
        reset_cycle(1'b0, "rst_mid");
        push_quarter("restart", 8);
        startup_check("restart");
        step(8);
        $display("scenario restart done, pending=%0d", sb_q.size());

        // Increment change after 5 edges: phase continues from acc = 0x4000_0000.
        reset_cycle(1'b1, "rst_d");
        phi_inc_i = 32'h4000_0000;
        push(25, 1'b1, "inc_change", 0);
        push(8191, 1'b1, "inc_change", 1);
        push(-25, 1'b1, "inc_change", 2);
        push(-8191, 1'b1, "inc_change", 3);
        push(25, 1'b1, "inc_change", 4);
        for (int n = 5; n < 11; n++) push((n % 2) ? 8191 : -8191, 1'b1, "inc_change", n);
        clken = 1'b1;
        step(5);
        phi_inc_i = 32'h8000_0000;
        step(8);
        $display("scenario inc_change done, pending=%0d", sb_q.size());

        clken = 1'b0;
        step(2);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
